// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus shared by the two result sources and the register-file write port.
// The arbiter sits on the slave side; the pipeline/test driver sits on the master side.
interface regfile_write_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 16
);
  logic              a_valid;
  logic              a_ready;
  logic [AW-1:0]     a_rd;
  logic [DW-1:0]     a_data;
  logic              b_valid;
  logic              b_ready;
  logic [AW-1:0]     b_rd;
  logic [DW-1:0]     b_data;
  logic              we;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [2**AW-1:0]  pending;
  logic [CW-1:0]     stall_cnt;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  a_ready, b_ready, we, wr_addr, wr_data, pending, stall_cnt
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output a_ready, b_ready, we, wr_addr, wr_data, pending, stall_cnt
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-source writeback arbiter for a single register-file write port: one holding
// register per source, round-robin grant (B wins same-destination ties), pending mask.
module regfile_write_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  regfile_write_arbiter_if.slave  wb
);

  logic              ha_valid_r;
  logic [AW-1:0]     ha_rd_r;
  logic [DW-1:0]     ha_data_r;
  logic              hb_valid_r;
  logic [AW-1:0]     hb_rd_r;
  logic [DW-1:0]     hb_data_r;
  logic              rr_r;
  logic [CW-1:0]     stall_r;

  logic              grant_a_s;
  logic              grant_b_s;
  logic              a_ready_s;
  logic              b_ready_s;
  logic              stall_s;
  logic [AW-1:0]     wr_addr_s;
  logic [DW-1:0]     wr_data_s;
  logic [2**AW-1:0]  pending_s;

  function automatic logic [2**AW-1:0] decode_rd(input logic [AW-1:0] rd);
    decode_rd = {{(2**AW-1){1'b0}}, 1'b1} << rd;
  endfunction

  // Grant selection; B wins same-destination ties because it carries the older instruction.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (reset) begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end else begin
      case ({ha_valid_r, hb_valid_r})
        2'b10: grant_a_s = 1'b1;
        2'b01: grant_b_s = 1'b1;
        2'b11: begin
          if ((ha_rd_r == hb_rd_r) || rr_r) begin
            grant_b_s = 1'b1;
          end else begin
            grant_a_s = 1'b1;
          end
        end
        default: begin
          grant_a_s = 1'b0;
          grant_b_s = 1'b0;
        end
      endcase
    end
  end

  // Handshake, write-port muxing and pending mask, all forced quiet while in reset.
  always_comb begin
    a_ready_s = 1'b0;
    b_ready_s = 1'b0;
    stall_s   = 1'b0;
    wr_addr_s = {AW{1'b0}};
    wr_data_s = {DW{1'b0}};
    pending_s = {(2**AW){1'b0}};
    if (reset) begin
      a_ready_s = 1'b0;
      b_ready_s = 1'b0;
    end else begin
      a_ready_s = !ha_valid_r || grant_a_s;
      b_ready_s = !hb_valid_r || grant_b_s;
      stall_s   = (ha_valid_r && !grant_a_s) || (hb_valid_r && !grant_b_s);
      if (grant_a_s) begin
        wr_addr_s = ha_rd_r;
        wr_data_s = ha_data_r;
      end else if (grant_b_s) begin
        wr_addr_s = hb_rd_r;
        wr_data_s = hb_data_r;
      end else begin
        wr_addr_s = {AW{1'b0}};
        wr_data_s = {DW{1'b0}};
      end
      if (ha_valid_r) begin
        pending_s = pending_s | decode_rd(ha_rd_r);
      end else begin
        pending_s = pending_s;
      end
      if (hb_valid_r) begin
        pending_s = pending_s | decode_rd(hb_rd_r);
      end else begin
        pending_s = pending_s;
      end
      pending_s[0] = 1'b0;
    end
  end

  // Holding registers, round-robin pointer and saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      ha_valid_r <= 1'b0;
      ha_rd_r    <= {AW{1'b0}};
      ha_data_r  <= {DW{1'b0}};
      hb_valid_r <= 1'b0;
      hb_rd_r    <= {AW{1'b0}};
      hb_data_r  <= {DW{1'b0}};
      rr_r       <= 1'b1;
      stall_r    <= {CW{1'b0}};
    end else begin
      // Writes to R0 are accepted but parked as invalid so they never issue.
      if (wb.a_valid && a_ready_s) begin
        ha_valid_r <= (wb.a_rd != {AW{1'b0}});
        ha_rd_r    <= wb.a_rd;
        ha_data_r  <= wb.a_data;
      end else if (grant_a_s) begin
        ha_valid_r <= 1'b0;
      end
      if (wb.b_valid && b_ready_s) begin
        hb_valid_r <= (wb.b_rd != {AW{1'b0}});
        hb_rd_r    <= wb.b_rd;
        hb_data_r  <= wb.b_data;
      end else if (grant_b_s) begin
        hb_valid_r <= 1'b0;
      end
      if (ha_valid_r && hb_valid_r) begin
        rr_r <= grant_a_s;
      end
      if (stall_s && (stall_r != {CW{1'b1}})) begin
        stall_r <= stall_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign wb.a_ready   = a_ready_s;
  assign wb.b_ready   = b_ready_s;
  assign wb.we        = grant_a_s || grant_b_s;
  assign wb.wr_addr   = wr_addr_s;
  assign wb.wr_data   = wr_data_s;
  assign wb.pending   = pending_s;
  assign wb.stall_cnt = stall_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: inputs change 1 time unit after each rising
// edge, outputs are checked at that same point against hand-derived values.
module tb_regfile_write_arbiter;

  logic clk;
  logic reset;
  int   cmp_cnt;
  int   err_cnt;

  regfile_write_arbiter_if #(.DW(32), .AW(5), .CW(16)) bus ();

  regfile_write_arbiter #(.DW(32), .AW(5), .CW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    cmp_cnt++;
    if (observed !== expected) begin
      err_cnt++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_port(input string tag, input logic exp_we, input logic [31:0] exp_addr,
                            input logic [31:0] exp_data);
    check_value({tag, ".we"}, 32'(bus.we), 32'(exp_we));
    check_value({tag, ".addr"}, 32'(bus.wr_addr), exp_addr);
    check_value({tag, ".data"}, bus.wr_data, exp_data);
  endtask

  task automatic check_ready(input string tag, input logic exp_a, input logic exp_b);
    check_value({tag, ".a_ready"}, 32'(bus.a_ready), 32'(exp_a));
    check_value({tag, ".b_ready"}, 32'(bus.b_ready), 32'(exp_b));
  endtask

  initial begin
    cmp_cnt      = 0;
    err_cnt      = 0;
    reset        = 1'b1;
    bus.a_valid  = 1'b0;
    bus.a_rd     = 5'd0;
    bus.a_data   = 32'd0;
    bus.b_valid  = 1'b0;
    bus.b_rd     = 5'd0;
    bus.b_data   = 32'd0;

    // reset held for two edges
    repeat (2) next_cycle();
    check_port("rst", 1'b0, 32'd0, 32'd0);
    check_ready("rst", 1'b0, 1'b0);
    check_value("rst.pending", bus.pending, 32'd0);
    reset = 1'b0;
    next_cycle();
    check_port("idle", 1'b0, 32'd0, 32'd0);
    check_ready("idle", 1'b1, 1'b1);
    check_value("idle.pending", bus.pending, 32'd0);
    check_value("idle.stall", 32'(bus.stall_cnt), 32'd0);

    // single uncontested write
    bus.a_valid = 1'b1; bus.a_rd = 5'd5; bus.a_data = 32'hDEADBEEF;
    next_cycle();
    bus.a_valid = 1'b0;
    check_port("single", 1'b1, 32'd5, 32'hDEADBEEF);
    check_value("single.pending", bus.pending, 32'h0000_0020);
    next_cycle();
    check_port("single.after", 1'b0, 32'd0, 32'd0);
    check_value("single.after.pending", bus.pending, 32'd0);
    check_value("single.stall", 32'(bus.stall_cnt), 32'd0);

    // contention: A sends A0,A1 to r3; B sends B0,B1,B2 to r7; rr starts favouring B
    bus.a_valid = 1'b1; bus.a_rd = 5'd3; bus.a_data = 32'h0000_00A0;
    bus.b_valid = 1'b1; bus.b_rd = 5'd7; bus.b_data = 32'h0000_00B0;
    next_cycle();
    check_port("cont1", 1'b1, 32'd7, 32'h0000_00B0);
    check_ready("cont1", 1'b0, 1'b1);
    check_value("cont1.pending", bus.pending, 32'h0000_0088);
    bus.a_data = 32'h0000_00A1; bus.b_data = 32'h0000_00B1;
    next_cycle();
    check_port("cont2", 1'b1, 32'd3, 32'h0000_00A0);
    check_ready("cont2", 1'b1, 1'b0);
    bus.b_data = 32'h0000_00B2;
    next_cycle();
    check_port("cont3", 1'b1, 32'd7, 32'h0000_00B1);
    check_ready("cont3", 1'b0, 1'b1);
    bus.a_valid = 1'b0;
    next_cycle();
    check_port("cont4", 1'b1, 32'd3, 32'h0000_00A1);
    check_ready("cont4", 1'b1, 1'b0);
    check_value("cont4.pending", bus.pending, 32'h0000_0088);
    bus.b_valid = 1'b0;
    next_cycle();
    check_port("cont5", 1'b1, 32'd7, 32'h0000_00B2);
    check_ready("cont5", 1'b1, 1'b1);
    check_value("cont5.pending", bus.pending, 32'h0000_0080);
    next_cycle();
    check_port("cont.drained", 1'b0, 32'd0, 32'd0);
    check_value("cont.stall", 32'(bus.stall_cnt), 32'd4);

    // same destination: B (older) must land first, A last
    bus.a_valid = 1'b1; bus.a_rd = 5'd9; bus.a_data = 32'h0000_0001;
    bus.b_valid = 1'b1; bus.b_rd = 5'd9; bus.b_data = 32'h0000_0002;
    next_cycle();
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    check_port("same1", 1'b1, 32'd9, 32'h0000_0002);
    check_value("same1.pending", bus.pending, 32'h0000_0200);
    next_cycle();
    check_port("same2", 1'b1, 32'd9, 32'h0000_0001);
    check_value("same2.pending", bus.pending, 32'h0000_0200);
    next_cycle();
    check_port("same.after", 1'b0, 32'd0, 32'd0);
    check_value("same.stall", 32'(bus.stall_cnt), 32'd5);

    // R0 filter
    bus.a_valid = 1'b1; bus.a_rd = 5'd0; bus.a_data = 32'hFFFFFFFF;
    check_ready("r0.offer", 1'b1, 1'b1);
    next_cycle();
    bus.a_valid = 1'b0;
    check_port("r0", 1'b0, 32'd0, 32'd0);
    check_value("r0.pending", bus.pending, 32'd0);
    check_ready("r0", 1'b1, 1'b1);
    check_value("r0.stall", 32'(bus.stall_cnt), 32'd5);

    // throughput: one A write per cycle, rd 1..8
    bus.a_valid = 1'b1; bus.a_rd = 5'd1; bus.a_data = 32'h0000_0101;
    for (int k = 1; k <= 8; k++) begin
      next_cycle();
      check_port($sformatf("tput%0d", k), 1'b1, 32'(k), 32'h0000_0100 + 32'(k));
      check_value($sformatf("tput%0d.a_ready", k), 32'(bus.a_ready), 32'd1);
      if (k < 8) begin
        bus.a_rd   = 5'(k + 1);
        bus.a_data = 32'h0000_0100 + 32'(k + 1);
      end else begin
        bus.a_valid = 1'b0;
      end
    end
    next_cycle();
    check_port("tput.after", 1'b0, 32'd0, 32'd0);
    check_value("tput.stall", 32'(bus.stall_cnt), 32'd5);

    // reset while both entries are held: the writes must be dropped
    bus.a_valid = 1'b1; bus.a_rd = 5'd10; bus.a_data = 32'h0000_AAAA;
    bus.b_valid = 1'b1; bus.b_rd = 5'd11; bus.b_data = 32'h0000_BBBB;
    next_cycle();
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_port("midrst", 1'b0, 32'd0, 32'd0);
    check_ready("midrst", 1'b0, 1'b0);
    check_value("midrst.pending", bus.pending, 32'd0);
    next_cycle();
    reset = 1'b0;
    #1;
    check_port("postrst", 1'b0, 32'd0, 32'd0);
    check_ready("postrst", 1'b1, 1'b1);
    check_value("postrst.pending", bus.pending, 32'd0);
    check_value("postrst.stall", 32'(bus.stall_cnt), 32'd0);
    next_cycle();
    check_port("postrst2", 1'b0, 32'd0, 32'd0);
    check_value("postrst2.pending", bus.pending, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
